// File: rtl/row_array_arbiter.sv
// Round-robin arbiter sharing a small row array among N_REQ requesters.
// After reset (or i_clear) every row is swept to INIT_VAL before any request is granted.
module row_array_arbiter #(
   parameter int          N_REQ    = 4,
   parameter int          ROWS     = 10,
   parameter int          WIDTH    = 10,
   parameter int unsigned INIT_VAL = 1,
   parameter int          AW       = $clog2(ROWS),
   parameter int          IW       = $clog2(N_REQ)
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_clear,
   input  logic [N_REQ-1:0]       i_req_valid,
   input  logic [N_REQ-1:0]       i_req_write,
   input  logic [N_REQ*AW-1:0]    i_req_addr,
   input  logic [N_REQ*WIDTH-1:0] i_req_wdata,
   output logic [N_REQ-1:0]       o_req_ready,
   output logic                   o_rsp_valid,
   output logic [IW-1:0]          o_rsp_id,
   output logic [WIDTH-1:0]       o_rsp_rdata,
   output logic                   o_rsp_err,
   output logic                   o_wr_err,
   output logic                   o_init_busy
);

   typedef enum logic {ST_INIT, ST_SERVE} state_t;

   localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT_VAL);

   state_t           state_q, state_d;
   logic [AW-1:0]    sweepPtr_q, sweepPtr_d;
   logic [IW-1:0]    rrPtr_q, rrPtr_d;
   logic             busy_q, busy_d;
   logic             rspValid_q, rspValid_d;
   logic [IW-1:0]    rspId_q, rspId_d;
   logic [WIDTH-1:0] rspData_q, rspData_d;
   logic             rspErr_q, rspErr_d;
   logic             wrErr_q, wrErr_d;

   logic [WIDTH-1:0] mem_q [ROWS];
   logic             memWe;
   logic [AW-1:0]    memWaddr;
   logic [WIDTH-1:0] memWdata;

   logic             gntFound;
   logic [IW-1:0]    gntId;
   int               idx;
   logic [IW-1:0]    idxN;
   logic [AW-1:0]    selAddr;
   logic [WIDTH-1:0] selWdata;
   logic             selWrite;
   logic             inRange;

   // Rotating priority scan starting at the round-robin pointer
   always_comb begin
      gntFound = 1'b0;
      gntId    = '0;
      idx      = 0;
      idxN     = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = int'(rrPtr_q) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         idxN = IW'(idx);
         if (!gntFound && i_req_valid[idxN]) begin
            gntFound = 1'b1;
            gntId    = idxN;
         end
      end
   end

   always_comb begin
      selAddr  = '0;
      selWdata = '0;
      selWrite = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (gntId == IW'(k)) begin
            selAddr  = i_req_addr[k*AW +: AW];
            selWdata = i_req_wdata[k*WIDTH +: WIDTH];
            selWrite = i_req_write[k];
         end
      end
      inRange = ({1'b0, selAddr} < (AW+1)'(ROWS));
   end

   always_comb begin
      state_d     = state_q;
      sweepPtr_d  = sweepPtr_q;
      rrPtr_d     = rrPtr_q;
      o_req_ready = '0;
      memWe       = 1'b0;
      memWaddr    = sweepPtr_q;
      memWdata    = INIT_W;
      rspValid_d  = 1'b0;
      rspId_d     = '0;
      rspData_d   = '0;
      rspErr_d    = 1'b0;
      wrErr_d     = 1'b0;
      case (state_q)
         ST_INIT: begin
            memWe = 1'b1;
            if (sweepPtr_q == AW'(ROWS-1)) begin
               sweepPtr_d = '0;
               state_d    = ST_SERVE;
            end else begin
               sweepPtr_d = sweepPtr_q + 1'b1;
            end
         end
         ST_SERVE: begin
            // A clear pre-empts arbitration; the pointer is kept for after the sweep
            if (i_clear) begin
               state_d    = ST_INIT;
               sweepPtr_d = '0;
            end else if (gntFound) begin
               o_req_ready[gntId] = 1'b1;
               rrPtr_d = (gntId == IW'(N_REQ-1)) ? '0 : gntId + 1'b1;
               if (selWrite) begin
                  if (inRange) begin
                     memWe    = 1'b1;
                     memWaddr = selAddr;
                     memWdata = selWdata;
                  end else begin
                     wrErr_d = 1'b1;
                  end
               end else begin
                  rspValid_d = 1'b1;
                  rspId_d    = gntId;
                  rspErr_d   = !inRange;
                  rspData_d  = inRange ? mem_q[selAddr] : '0;
               end
            end
         end
         default: state_d = ST_INIT;
      endcase
      busy_d = (state_d == ST_INIT);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_INIT;
         sweepPtr_q <= '0;
         rrPtr_q    <= '0;
         busy_q     <= 1'b1;
         rspValid_q <= 1'b0;
         rspId_q    <= '0;
         rspData_q  <= '0;
         rspErr_q   <= 1'b0;
         wrErr_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         sweepPtr_q <= sweepPtr_d;
         rrPtr_q    <= rrPtr_d;
         busy_q     <= busy_d;
         rspValid_q <= rspValid_d;
         rspId_q    <= rspId_d;
         rspData_q  <= rspData_d;
         rspErr_q   <= rspErr_d;
         wrErr_q    <= wrErr_d;
      end
   end

   // Storage itself is not reset; the sweep defines its contents
   always_ff @(posedge i_clk) begin
      if (memWe) mem_q[memWaddr] <= memWdata;
   end

   assign o_rsp_valid = rspValid_q;
   assign o_rsp_id    = rspId_q;
   assign o_rsp_rdata = rspData_q;
   assign o_rsp_err   = rspErr_q;
   assign o_wr_err    = wrErr_q;
   assign o_init_busy = busy_q;

endmodule

// File: tb/tb_row_array_arbiter.sv
// Bench for row_array_arbiter: a countdown/array model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_row_array_arbiter;

   localparam int N_REQ = 4;
   localparam int ROWS  = 10;
   localparam int WIDTH = 10;
   localparam int AW    = 4;
   localparam int IW    = 2;
   localparam int INIT_VAL = 1;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   clear = 1'b0;
   logic [N_REQ-1:0]       reqValid = '0;
   logic [N_REQ-1:0]       reqWrite = '0;
   logic [N_REQ*AW-1:0]    reqAddr = '0;
   logic [N_REQ*WIDTH-1:0] reqWdata = '0;
   logic [N_REQ-1:0]       reqReady;
   logic                   rspValid;
   logic [IW-1:0]          rspId;
   logic [WIDTH-1:0]       rspData;
   logic                   rspErr;
   logic                   wrErr;
   logic                   initBusy;

   int checks = 0;
   int errors = 0;

   row_array_arbiter #(
      .N_REQ(N_REQ), .ROWS(ROWS), .WIDTH(WIDTH), .INIT_VAL(INIT_VAL)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_clear(clear),
      .i_req_valid(reqValid),
      .i_req_write(reqWrite),
      .i_req_addr(reqAddr),
      .i_req_wdata(reqWdata),
      .o_req_ready(reqReady),
      .o_rsp_valid(rspValid),
      .o_rsp_id(rspId),
      .o_rsp_rdata(rspData),
      .o_rsp_err(rspErr),
      .o_wr_err(wrErr),
      .o_init_busy(initBusy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: rows still to sweep, row contents, rotation pointer, and what the
   // registered outputs must show after the coming edge.
   int   mMem [ROWS];
   int   mInitLeft = ROWS;
   int   mRr = 0;
   logic mRspValid = 1'b0;
   int   mRspId = 0;
   int   mRspData = 0;
   logic mRspErr = 1'b0;
   logic mWrErr = 1'b0;

   always @(negedge clk) begin
      int k;
      int a;
      logic found;
      logic [N_REQ-1:0] expReady;
      if (rst) begin
         mInitLeft = ROWS;
         mRr = 0;
         mRspValid = 1'b0;
         mWrErr = 1'b0;
         checkOutput("rstReady", reqReady, 0);
         checkOutput("rstRspValid", rspValid, 0);
         checkOutput("rstRspId", rspId, 0);
         checkOutput("rstRspData", rspData, 0);
         checkOutput("rstRspErr", rspErr, 0);
         checkOutput("rstWrErr", wrErr, 0);
         checkOutput("rstBusy", initBusy, 1);
      end else begin
         found = 1'b0;
         k = 0;
         expReady = '0;
         if (mInitLeft == 0 && !clear) begin
            for (int i = 0; i < N_REQ; i++) begin
               if (!found && reqValid[(mRr + i) % N_REQ]) begin
                  found = 1'b1;
                  k = (mRr + i) % N_REQ;
               end
            end
         end
         if (found) expReady[k] = 1'b1;
         checkOutput("mdlReady", reqReady, expReady);
         checkOutput("mdlBusy", initBusy, (mInitLeft > 0) ? 1 : 0);
         checkOutput("mdlRspValid", rspValid, mRspValid);
         checkOutput("mdlWrErr", wrErr, mWrErr);
         if (mRspValid) begin
            checkOutput("mdlRspId", rspId, mRspId);
            checkOutput("mdlRspData", rspData, mRspData);
            checkOutput("mdlRspErr", rspErr, mRspErr);
         end
         mRspValid = 1'b0;
         mWrErr = 1'b0;
         if (mInitLeft > 0) begin
            mMem[ROWS - mInitLeft] = INIT_VAL % (1 << WIDTH);
            mInitLeft--;
         end else if (clear) begin
            mInitLeft = ROWS;
         end else if (found) begin
            mRr = (k + 1) % N_REQ;
            a = int'(reqAddr[k*AW +: AW]);
            if (reqWrite[k]) begin
               if (a < ROWS) mMem[a] = int'(reqWdata[k*WIDTH +: WIDTH]);
               else mWrErr = 1'b1;
            end else begin
               mRspValid = 1'b1;
               mRspId = k;
               mRspErr = (a >= ROWS);
               mRspData = (a < ROWS) ? mMem[a] : 0;
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int k, input logic v, input logic w, input int a, input int d);
      reqValid[k] = v;
      reqWrite[k] = w;
      reqAddr[k*AW +: AW] = AW'(a);
      reqWdata[k*WIDTH +: WIDTH] = WIDTH'(d);
   endtask

   task automatic expectInitSweep();
      for (int c = 0; c < ROWS; c++) begin
         @(negedge clk);
         checkOutput("sweepBusy", initBusy, 1);
         checkOutput("sweepNoGrant", reqReady, 0);
         tick();
      end
   endtask

   task automatic doRead(input int k, input int a, input int expData, input int expErr);
      applyStimulus(k, 1'b1, 1'b0, a, 0);
      @(negedge clk);
      checkOutput("readGrant", reqReady, 1 << k);
      tick();
      applyStimulus(k, 1'b0, 1'b0, 0, 0);
      @(negedge clk);
      checkOutput("readRspValid", rspValid, 1);
      checkOutput("readRspId", rspId, k);
      checkOutput("readRspData", rspData, expData);
      checkOutput("readRspErr", rspErr, expErr);
      tick();
   endtask

   task automatic doWrite(input int k, input int a, input int d);
      applyStimulus(k, 1'b1, 1'b1, a, d);
      @(negedge clk);
      checkOutput("writeGrant", reqReady, 1 << k);
      tick();
      applyStimulus(k, 1'b0, 1'b0, 0, 0);
   endtask

   initial begin
      // Power-up reset and initial sweep
      tick(3);
      rst = 1'b0;
      expectInitSweep();
      @(negedge clk);
      checkOutput("busyAfterSweep", initBusy, 0);
      tick();
      for (int r = 0; r < ROWS; r++) doRead(0, r, 'h001, 0);

      // Bring the pointer back to 0, then stream reads from all requesters
      doRead(3, 0, 'h001, 0);
      for (int k = 0; k < N_REQ; k++) applyStimulus(k, 1'b1, 1'b0, k, 0);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         checkOutput("rrGrant", reqReady, 1 << (c % 4));
         if (c > 0) begin
            checkOutput("rrRspValid", rspValid, 1);
            checkOutput("rrRspId", rspId, (c - 1) % 4);
         end
         tick();
      end
      reqValid = '0;
      @(negedge clk);
      checkOutput("rrLastRspId", rspId, 3);
      tick();

      // Write followed immediately by a read of the same row
      doWrite(2, 7, 'h3A5);
      doRead(0, 7, 'h3A5, 0);

      // Out-of-range read and write
      doRead(1, 12, 0, 1);
      doWrite(1, 15, 'h155);
      @(negedge clk);
      checkOutput("wrErrPulse", wrErr, 1);
      tick();
      @(negedge clk);
      checkOutput("wrErrDone", wrErr, 0);
      tick();
      for (int r = 0; r < ROWS; r++) doRead(0, r, (r == 7) ? 'h3A5 : 'h001, 0);

      // Clear while requester 1 waits
      doWrite(0, 3, 'h0FF);
      applyStimulus(1, 1'b1, 1'b0, 3, 0);
      clear = 1'b1;
      @(negedge clk);
      checkOutput("clearNoGrant", reqReady, 0);
      tick();
      clear = 1'b0;
      expectInitSweep();
      @(negedge clk);
      checkOutput("clearFirstGrant", reqReady, 4'b0010);
      checkOutput("clearBusyLow", initBusy, 0);
      tick();
      applyStimulus(1, 1'b0, 1'b0, 0, 0);
      @(negedge clk);
      checkOutput("clearRow3Valid", rspValid, 1);
      checkOutput("clearRow3Data", rspData, 'h001);
      checkOutput("clearRow3Id", rspId, 1);
      tick();

      // Reset in the middle of a read stream
      for (int k = 0; k < N_REQ; k++) applyStimulus(k, 1'b1, 1'b0, k, 0);
      tick(3);
      @(negedge clk);
      checkOutput("rspBeforeReset", rspValid, 1);
      tick();
      rst = 1'b1;
      #1;
      checkOutput("rspDropOnReset", rspValid, 0);
      checkOutput("busyOnReset", initBusy, 1);
      checkOutput("readyOnReset", reqReady, 0);
      tick();
      rst = 1'b0;
      expectInitSweep();
      @(negedge clk);
      checkOutput("grantAfterReset", reqReady, 4'b0001);
      tick();
      reqValid = '0;
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/row_array_arbiter.md
# row_array_arbiter

Shares one 10-row × 10-bit register array among several requesters. After reset it sweeps every row to a fixed initial value, then grants one read or write per cycle under round-robin arbitration. Read data returns through a registered response port. It sits between requester logic and the row/word storage that the surrounding module variables model.

## Interface

- N_REQ, default 4: number of requesters, range 2..8.
- ROWS, default 10: array depth.
- WIDTH, default 10: row width in bits.
- INIT_VAL, default 1: value written to every row during initialization, zero-extended to WIDTH.
- AW, derived as $clog2(ROWS): address width, 4 at the defaults.
- IW, derived as $clog2(N_REQ): requester-id width, 2 at the defaults.

Ports:
- i_clk  in  1  sole clock, rising edge.
- i_rst  in  1  reset, asynchronous and active-high.
- i_clear  in  1  pulse that requests re-initialization of all rows.
- i_req_valid  in  N_REQ  per-requester request valid.
- i_req_write  in  N_REQ  per-requester op: 1 = write, 0 = read.
- i_req_addr  in  N_REQ*AW  packed row addresses; requester k uses bits [k*AW +: AW].
- i_req_wdata  in  N_REQ*WIDTH  packed write data.
- o_req_ready  out  N_REQ  one-hot grant; at most one bit set.
- o_rsp_valid  out  1  read response valid, one-cycle pulse.
- o_rsp_id  out  IW  index of the requester that issued the read.
- o_rsp_rdata  out  WIDTH  read data.
- o_rsp_err  out  1  the responded read was out of range; qualified by o_rsp_valid.
- o_wr_err  out  1  one-cycle pulse on an accepted out-of-range write.
- o_init_busy  out  1  high while the INIT sweep runs.

## Operation

- State machine states: INIT and SERVE.
- Reset: state = INIT, sweep pointer = 0, round-robin pointer = 0. All o_* = 0 except o_init_busy = 1. Array contents are undefined until the sweep completes.
- INIT:
  - Each cycle writes INIT_VAL to row[sweep pointer], then increments the pointer.
  - After the write to row ROWS-1, the pointer returns to 0 and the state goes to SERVE.
  - o_req_ready = 0 throughout INIT.
  - i_clear is ignored while in INIT.
- SERVE:
  - Grant goes to the lowest index k ≥ rr_ptr (with wrap) whose i_req_valid is high.
  - o_req_ready[k] is combinational from i_req_valid and rr_ptr.
  - A transfer happens when valid & ready. On a transfer, rr_ptr ← (k+1) mod N_REQ. With no transfer, rr_ptr holds.
  - Write with addr < ROWS: row[addr] ← wdata at the clock edge.
  - Write with addr ≥ ROWS: array unchanged; o_wr_err pulses on the next cycle.
  - Read: the response is registered. The next cycle shows o_rsp_valid = 1, o_rsp_id = k, o_rsp_rdata = row[addr]. An out-of-range read returns rdata = 0 and o_rsp_err = 1.
  - i_clear = 1 in SERVE:
    - No grant is issued that cycle.
    - The state enters INIT on the next edge with the sweep pointer at 0.
    - rr_ptr is preserved.
    - A read accepted in the previous cycle still delivers its response.
- Requesters must hold valid, write, addr and wdata stable until they see ready. The block does not check this.
- Width rules:
  - addr is compared against ROWS as unsigned AW bits.
  - wdata is stored unmodified.
  - INIT_VAL is truncated to WIDTH if wider.

## Timing

- The INIT sweep takes exactly ROWS cycles: from reset deassertion to the first possible grant is ROWS cycles (10 by default).
- o_init_busy falls in the same cycle the state becomes SERVE.
- Throughput is one transfer per cycle in SERVE.
- Read latency is 1 cycle from the accepting edge to o_rsp_valid.
- Write-then-read: a read of row R accepted the cycle after a write to R returns the new data. Only one transfer occurs per cycle, so there is no same-cycle hazard.
- Asserting i_rst mid-operation:
  - All outputs go to their reset values immediately (asynchronous).
  - A pending response is dropped.
  - The sweep restarts from row 0.
- Every output except o_req_ready is driven directly from a flop.

## Test plan

- Reset, then idle for 10 cycles: o_init_busy is high for cycles 0–9 and low at cycle 10. Reads of rows 0..9 then return 0x001 with o_rsp_err = 0.
- All 4 requesters hold valid reads continuously from rr_ptr = 0: grants go 0,1,2,3,0,… one per cycle. o_rsp_id follows the same sequence one cycle later.
- Requester 2 writes 0x3A5 to row 7, then requester 0 reads row 7 on the next cycle: the response has o_rsp_rdata = 0x3A5 and o_rsp_id = 0.
- Read of row 12, then write of 0x155 to row 15: the read responds with rdata = 0 and o_rsp_err = 1. o_wr_err pulses once. Rows 0..9 are unchanged.
- Write 0x0FF to row 3, then pulse i_clear while requester 1 is valid:
  - No grant in the i_clear cycle.
  - o_init_busy is high for 10 cycles.
  - Row 3 then reads 0x001.
  - Requester 1 is granted first after the sweep.
- Assert i_rst for 1 cycle midway through a stream of reads: o_rsp_valid drops immediately, no stale response appears, and the sweep restarts (10 busy cycles).
